// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM states, oversampling
// constants and the baud divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE   = 16;
    localparam int SAMPLE_POINT = 7;

    // Rounded divider from system clock to the 16x oversampling tick rate.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: free-running 0..DIV-1 counter that emits a
// one-clock tick on DIV-1 and can be re-phased with clear.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_reg;

    // Count up and wrap at DIV-1; clear restarts the phase from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clear || cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // A tick coinciding with a clear would belong to the old phase, so drop it.
    assign tick = (cnt_reg == LAST) && !clear;

endmodule

// File: rtl/uart_rx_byte.sv
// 8-bit UART receiver, LSB first, one parity bit, one stop bit, 16x
// oversampling. Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3
// majority of the samples at counts 6, 7 and 8 instead of a single sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int PARITY_ODD  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       rx_parity_error,
    output logic       rx_frame_error
);
    localparam int         DIV     = calc_div(CLK_FREQ_HZ, BAUD);
    localparam logic [3:0] SP      = 4'(SAMPLE_POINT);
    localparam logic       PAR_ODD = (PARITY_ODD != 0);

    rx_state_t  state_reg, state_next;
    logic       sync1_reg, sync2_reg;
    logic       rxs;
    logic       tick;
    logic       clear_cnt;
    logic [3:0] samp_cnt_reg;
    logic [2:0] bit_idx_reg;
    logic [7:0] shreg_reg;
    logic       parity_bit_reg;
    logic       high_seen_reg;
    logic [7:0] rx_data_reg;
    logic       rx_ready_reg, rx_perr_reg, rx_ferr_reg;
    logic       decide, bit_val;
    logic       shift_en, par_cap, accept, frame_err;

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= uart_rx;
            sync2_reg <= sync1_reg;
        end
    end
    assign rxs = sync2_reg;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear_cnt),
        .tick  (tick)
    );

    // Tick counter within a bit period; realigned to the start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            samp_cnt_reg <= '0;
        end else if (clear_cnt) begin
            samp_cnt_reg <= '0;
        end else if (tick) begin
            samp_cnt_reg <= samp_cnt_reg + 4'd1;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic s6_reg, s7_reg;

    // Hold the first two of the three votes until the decision at count 8.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s6_reg <= 1'b1;
            s7_reg <= 1'b1;
        end else if (tick) begin
            if (samp_cnt_reg == SP - 4'd1) s6_reg <= rxs;
            if (samp_cnt_reg == SP)        s7_reg <= rxs;
        end
    end

    assign decide  = tick && (samp_cnt_reg == SP + 4'd1);
    assign bit_val = (s6_reg & s7_reg) | (s6_reg & rxs) | (s7_reg & rxs);
`else
    assign decide  = tick && (samp_cnt_reg == SP);
    assign bit_val = rxs;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-bit control strobes.
    always_comb begin
        state_next = state_reg;
        clear_cnt  = 1'b0;
        shift_en   = 1'b0;
        par_cap    = 1'b0;
        accept     = 1'b0;
        frame_err  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rxs) begin
                    clear_cnt  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (decide) state_next = bit_val ? IDLE : DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_idx_reg == 3'd7) state_next = PARITY;
                end
            end
            PARITY: begin
                if (decide) begin
                    par_cap    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (bit_val) begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // Line must read high on two consecutive ticks to leave a break.
                if (tick && rxs && high_seen_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift register, bit index, parity capture and break high-detector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_reg      <= '0;
            bit_idx_reg    <= '0;
            parity_bit_reg <= 1'b0;
            high_seen_reg  <= 1'b0;
        end else begin
            if (shift_en) begin
                shreg_reg   <= {bit_val, shreg_reg[7:1]};
                bit_idx_reg <= bit_idx_reg + 3'd1;
            end else if (state_reg != DATA) begin
                bit_idx_reg <= '0;
            end
            if (par_cap) parity_bit_reg <= bit_val;
            if (state_reg != BREAK) begin
                high_seen_reg <= 1'b0;
            end else if (tick) begin
                high_seen_reg <= rxs;
            end
        end
    end

    // Registered outputs: data and parity flag update only on a good stop bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_reg  <= '0;
            rx_ready_reg <= 1'b0;
            rx_perr_reg  <= 1'b0;
            rx_ferr_reg  <= 1'b0;
        end else begin
            rx_ready_reg <= accept;
            rx_ferr_reg  <= frame_err;
            if (accept) begin
                rx_data_reg <= shreg_reg;
                rx_perr_reg <= (^shreg_reg ^ parity_bit_reg) != PAR_ODD;
            end
        end
    end

    assign rx_data         = rx_data_reg;
    assign rx_ready        = rx_ready_reg;
    assign rx_parity_error = rx_perr_reg;
    assign rx_frame_error  = rx_ferr_reg;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at default parameters (bit = 864 clk).
// Expected bytes are queued as frames are sent and popped by a monitor.
module tb_uart_rx_byte;
    localparam int BIT        = 16 * 54;
    localparam int TICK       = 54;
    localparam bit PARITY_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_parity_error;
    logic       rx_frame_error;

    int vectors     = 0;
    int miscompares = 0;
    int ready_cnt   = 0;
    int ferr_cnt    = 0;
    logic prev_ready = 1'b0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_byte dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rx         (uart_rx),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .rx_parity_error (rx_parity_error),
        .rx_frame_error  (rx_frame_error)
    );

    // Monitor: pop expected {perr, data} on each rx_ready pulse.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (!reset) begin
            if (rx_frame_error) ferr_cnt++;
            if (rx_ready) begin
                ready_cnt++;
                vectors++;
                if (prev_ready) begin
                    miscompares++;
                    $display("FAIL ready_pulse_width: rx_ready high 2 clks, required 1");
                end
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_ready: got data=%02h perr=%0b, required no output",
                             rx_data, rx_parity_error);
                end else begin
                    exp = sb.pop_front();
                    if ({rx_parity_error, rx_data} !== exp) begin
                        miscompares++;
                        $display("FAIL rx_byte: got data=%02h perr=%0b, required data=%02h perr=%0b",
                                 rx_data, rx_parity_error, exp[7:0], exp[8]);
                    end else begin
                        $display("rx byte data=%02h perr=%0b", rx_data, rx_parity_error);
                    end
                end
            end
            prev_ready = rx_ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    task automatic send_bit(input logic b, input bit glitch);
        for (int i = 0; i < BIT; i++) begin
            uart_rx = (glitch && i >= 405 && i < 405 + TICK) ? ~b : b;
            @(negedge clk);
        end
    endtask

    // Start bit, 8 data bits LSB first, parity bit; optional one-tick glitch on one data bit.
    task automatic send_body(input logic [7:0] d, input logic p, input int glitch_bit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == glitch_bit);
        send_bit(p, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int glitch_bit);
        sb.push_back({((^d ^ p) != PARITY_ODD), d});
        send_body(d, p, glitch_bit);
        send_bit(1'b1, 1'b0);
    endtask

    task automatic idle(input int clks);
        uart_rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    task automatic check_drained(input string name, input int ready_before, input int n_exp);
        vectors++;
        if (sb.size() != 0 || ready_cnt - ready_before != n_exp) begin
            miscompares++;
            $display("FAIL %s: got %0d pulses (%0d pending), required %0d pulses",
                     name, ready_cnt - ready_before, sb.size(), n_exp);
        end
        sb.delete();
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if ({rx_data, rx_ready, rx_parity_error, rx_frame_error} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%02h rdy=%0b perr=%0b ferr=%0b, required all 0",
                     rx_data, rx_ready, rx_parity_error, rx_frame_error);
        end
        reset = 1'b0;
        idle(BIT);
    endtask

    task automatic test_basic();
        int r0 = ready_cnt;
        send_frame(8'h00, 1'b0, -1);
        idle(BIT);
        check_drained("basic_0x00", r0, 1);
    endtask

    task automatic test_parity();
        int r0 = ready_cnt;
        send_frame(8'h1A, 1'b0, -1);
        idle(BIT);
        send_frame(8'h1A, 1'b1, -1);
        idle(BIT);
        check_drained("parity", r0, 2);
    endtask

    task automatic test_back_to_back();
        int r0 = ready_cnt;
        logic [7:0] bytes [4] = '{8'h00, 8'h15, 8'h2A, 8'h0F};
        for (int i = 0; i < 4; i++) send_frame(bytes[i], ^bytes[i], -1);
        idle(BIT);
        check_drained("back_to_back", r0, 4);
    endtask

    task automatic test_false_start();
        int r0 = ready_cnt;
        int f0 = ferr_cnt;
        uart_rx = 1'b0;
        repeat (3 * TICK) @(negedge clk);
        idle(3 * BIT);
        vectors++;
        if (ready_cnt != r0 || ferr_cnt != f0) begin
            miscompares++;
            $display("FAIL false_start: got %0d ready %0d ferr pulses, required 0 and 0",
                     ready_cnt - r0, ferr_cnt - f0);
        end
`ifdef UART_RX_MAJORITY_EN
        send_frame(8'hA5, ^8'hA5, 3);
        idle(BIT);
        check_drained("glitch_reject", r0, 1);
`endif
    endtask

    task automatic test_frame_error();
        int r0 = ready_cnt;
        int f0 = ferr_cnt;
        send_body(8'h55, ^8'h55, -1);
        uart_rx = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        idle(2 * BIT);
        vectors++;
        if (ferr_cnt - f0 != 1 || ready_cnt != r0) begin
            miscompares++;
            $display("FAIL frame_error: got %0d ferr %0d ready pulses, required 1 and 0",
                     ferr_cnt - f0, ready_cnt - r0);
        end
        vectors++;
        if (rx_data !== 8'h0F) begin
            miscompares++;
            $display("FAIL frame_error_hold: got data=%02h, required 0f", rx_data);
        end
        send_frame(8'h33, ^8'h33, -1);
        idle(BIT);
        check_drained("after_break", r0, 1);
    endtask

    task automatic test_reset_mid();
        int r0;
        logic [7:0] d = 8'h77;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
        uart_rx = d[4];
        repeat (BIT / 2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if ({rx_data, rx_ready, rx_parity_error, rx_frame_error} !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got data=%02h rdy=%0b perr=%0b ferr=%0b, required all 0",
                     rx_data, rx_ready, rx_parity_error, rx_frame_error);
        end
        reset = 1'b0;
        r0 = ready_cnt;
        idle(2 * BIT);
        send_frame(8'h42, ^8'h42, -1);
        idle(BIT);
        check_drained("after_reset", r0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_false_start();
        test_frame_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
